pal_cfg_loader: RTL and testbench
=================================

Name: pal_cfg_loader

Overview:
- Upstream configuration front end for the PAL fabric.
- Accepts the PAL configuration bitstream as bytes over a valid/ready handshake and serialises it MSB-first onto the PAL's one-bit config input.
- Checks a trailing CRC-8 byte against the received data.
- Issues the one-cycle apply strobe that drives the PAL enable only when the CRC matches. A corrupted bitstream is never applied.

Parameters:
- CFG_BITS, 384, total config bits (AND plane 2*8*16 = 256, plus OR plane 16*8 = 128); must be a multiple of 8.
- CRC_POLY, 8'h07, CRC-8 generator polynomial (init 8'h00, MSB-first, no reflection, no final XOR).

Ports:
- CLK  in  1  clock
- RES  in  1  synchronous reset, active high
- START  in  1  begin a load; sampled only in IDLE
- DIN  in  8  bitstream byte
- DIN_VALID  in  1  DIN holds a valid byte
- DIN_READY  out  1  loader accepts DIN this cycle
- CFG_OUT  out  1  serial config bit to the PAL
- CFG_SHIFT  out  1  CFG_OUT is valid; the PAL shifts one bit this cycle
- CFG_APPLY  out  1  one-cycle strobe to the PAL enable
- BUSY  out  1  load in progress
- DONE  out  1  sticky: last load applied successfully
- ERR  out  1  sticky: last load failed CRC

Behaviour:
- Reset (synchronous, RES=1): state IDLE; all outputs 0; shift register, bit counter, byte counter and CRC cleared. RES overrides every other input in the same cycle.
- Handshake: a byte transfers on a cycle where DIN_READY & DIN_VALID are both high. DIN_VALID may drop at any time. DIN is ignored while DIN_READY=0.
- States:
  - IDLE: DIN_READY=0, BUSY=0. START=1 clears DONE, ERR and CRC, then goes to LOAD.
  - LOAD: BUSY=1.
    - DIN_READY=1 when the shift register is empty, or it is shifting its last bit (bit count 7) and byte count < CFG_BITS/8.
    - On accept: byte goes to the shift register; CRC is updated with the byte (combinational 8-step update, registered).
    - Each following cycle with a non-empty register: CFG_SHIFT=1, CFG_OUT = register MSB, register shifts left.
    - Back-to-back bytes give a gapless stream of 8 bits per byte. Input gaps produce CFG_SHIFT=0 gaps; no bit is lost or duplicated.
    - After CFG_BITS bits have been shifted, go to CHECK.
  - CHECK: DIN_READY=1, CFG_SHIFT=0. Accept one byte and compare it with the registered CRC.
    - Equal: go to APPLY.
    - Not equal: set ERR=1 and go to IDLE.
  - APPLY: CFG_APPLY=1 for exactly one cycle, DONE=1, then go to IDLE.
- Latency (zero-gap input):
  - First CFG_SHIFT occurs 1 cycle after the first accept.
  - The last data bit appears at cycle CFG_BITS after the first accept.
  - CFG_APPLY occurs 2 cycles after the CRC byte is accepted.
- Counters:
  - Bit counter is 3 bits and wraps 7 to 0 per byte.
  - Byte counter is ceil(log2(CFG_BITS/8 + 1)) bits and saturates at CFG_BITS/8.
  - Total shifted bits are exactly CFG_BITS per load.
- Boundary conditions:
  - START outside IDLE is ignored.
  - START in the same cycle as the IDLE entry from APPLY or ERR is taken on the next cycle.
  - RES during LOAD or CHECK aborts the load with no CFG_APPLY. The PAL keeps its previously applied config, because apply is the only commit.
  - DONE and ERR are mutually exclusive and hold until the next START or RES.
  - A CRC byte arriving early is not accepted: DIN_READY=0 until the final data bit has shifted.

Decomposition:
- Package pal_cfg_pkg holds:
  - state enum (IDLE, LOAD, CHECK, APPLY)
  - CFG_BITS default, derived from the PAL N, M, P
  - CRC_POLY
  - function crc8_byte(crc, byte)
- One sub-module, pal_cfg_serializer: byte-in/bit-out shift register with bit counter, exposing ready/valid in and CFG_OUT/CFG_SHIFT out.
- The FSM and CRC stay in the top block.

Test Plan:
- All-zero load: START, 48 bytes of 0x00 back-to-back, then CRC 0x00.
  - Required: 384 consecutive CFG_SHIFT cycles with CFG_OUT=0; CFG_APPLY pulse 2 cycles after the CRC accept; DONE=1, ERR=0.
- Bit order: first byte 0xA5, remaining 47 bytes 0x00, then the model-computed CRC.
  - Required: first 8 CFG_OUT bits are 1,0,1,0,0,1,0,1; DONE=1.
- CRC fail: repeat the all-zero load with CRC byte 0x01.
  - Required: ERR=1, DONE=0, CFG_APPLY never asserts, state returns to IDLE.
- Backpressure: random DIN_VALID at 30% duty with a random data stream.
  - Required: captured CFG_OUT sequence equals the input bits MSB-first; exactly 384 CFG_SHIFT cycles; apply on correct CRC.
- Reset mid-load: RES=1 after 10 bytes.
  - Required: next cycle all outputs 0 and no CFG_APPLY. A subsequent full load then succeeds.
- START while BUSY: pulse START at byte 5.
  - Required: load unaffected, exactly one CFG_APPLY. START=1 held in the APPLY cycle starts a new load one cycle later.

Source files
------------

// File: rtl/pal_cfg_pkg.sv
// Shared definitions for the PAL configuration loader: PAL geometry,
// default bitstream length, CRC polynomial, state encoding and the
// byte-wide CRC-8 update used by the loader.
package pal_cfg_pkg;

  // PAL geometry: inputs, product terms, outputs.
  localparam int PAL_N = 8;
  localparam int PAL_M = 16;
  localparam int PAL_P = 8;

  // AND plane carries true and complement of every input per product term,
  // OR plane selects product terms per output.
  localparam int CFG_BITS_DEFAULT = 2 * PAL_N * PAL_M + PAL_M * PAL_P;

  // CRC-8, init 0x00, MSB-first, unreflected, no final XOR.
  localparam logic [7:0] CRC_POLY_DEFAULT = 8'h07;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_LOAD  = 2'd1,
    ST_CHECK = 2'd2,
    ST_APPLY = 2'd3
  } cfg_state_e;

  // Folds one data byte into the running CRC, eight polynomial steps unrolled.
  function automatic logic [7:0] crc8_byte(input logic [7:0] crc,
                                           input logic [7:0] data,
                                           input logic [7:0] poly);
    logic [7:0] c;
    c = crc ^ data;
    for (int i = 0; i < 8; i++) begin
      if (c[7]) begin
        c = {c[6:0], 1'b0} ^ poly;
      end else begin
        c = {c[6:0], 1'b0};
      end
    end
    return c;
  endfunction

endpackage

// File: rtl/pal_cfg_serializer.sv
// Byte-in / bit-out shift register feeding the PAL's serial config input.
// A new byte can be taken while the last bit of the current one is on the
// wire, so back-to-back bytes produce a gapless bit stream.
module pal_cfg_serializer (
  input  logic       clk,
  input  logic       srst,
  input  logic       en_i,
  input  logic [7:0] data_i,
  input  logic       valid_i,
  output logic       ready_o,
  output logic       cfg_out_o,
  output logic       cfg_shift_o,
  output logic       last_bit_o
);

  logic [7:0] sr_q;
  logic [7:0] sr_d;
  logic [2:0] cnt_q;
  logic [2:0] cnt_d;
  logic       full_q;
  logic       full_d;
  logic       accept;

  assign last_bit_o  = full_q && (cnt_q == 3'd7);
  assign ready_o     = en_i && (!full_q || last_bit_o);
  assign accept      = ready_o && valid_i;
  assign cfg_shift_o = full_q;
  assign cfg_out_o   = full_q && sr_q[7];

  // Shift one bit per cycle while loaded; a fresh byte overrides the shift.
  always_comb begin
    sr_d   = sr_q;
    cnt_d  = cnt_q;
    full_d = full_q;
    if (full_q) begin
      sr_d  = {sr_q[6:0], 1'b0};
      cnt_d = cnt_q + 3'd1;
      if (cnt_q == 3'd7) begin
        full_d = 1'b0;
      end
    end
    if (accept) begin
      sr_d   = data_i;
      cnt_d  = 3'd0;
      full_d = 1'b1;
    end
  end

  // Shift register, bit counter and occupancy flag.
  always_ff @(posedge clk) begin
    if (srst) begin
      sr_q   <= 8'h00;
      cnt_q  <= 3'd0;
      full_q <= 1'b0;
    end else begin
      sr_q   <= sr_d;
      cnt_q  <= cnt_d;
      full_q <= full_d;
    end
  end

endmodule

// File: rtl/pal_cfg_loader.sv
// PAL configuration front end: takes the bitstream as bytes, serialises it
// MSB-first to the PAL, checks the trailing CRC-8 byte and only then
// strobes the PAL enable. A bitstream with a bad CRC is never applied.
module pal_cfg_loader
  import pal_cfg_pkg::*;
#(
  parameter int         CFG_BITS = CFG_BITS_DEFAULT,
  parameter logic [7:0] CRC_POLY = CRC_POLY_DEFAULT
) (
  input  logic       CLK,
  input  logic       RES,
  input  logic       START,
  input  logic [7:0] DIN,
  input  logic       DIN_VALID,
  output logic       DIN_READY,
  output logic       CFG_OUT,
  output logic       CFG_SHIFT,
  output logic       CFG_APPLY,
  output logic       BUSY,
  output logic       DONE,
  output logic       ERR
);

  localparam int                NBYTES   = CFG_BITS / 8;
  localparam int                BYTE_W   = $clog2(NBYTES + 1);
  localparam logic [BYTE_W-1:0] NBYTES_C = BYTE_W'(NBYTES);

  localparam logic [1:0] IDLE  = ST_IDLE;
  localparam logic [1:0] LOAD  = ST_LOAD;
  localparam logic [1:0] CHECK = ST_CHECK;
  localparam logic [1:0] APPLY = ST_APPLY;

  logic [1:0]        state_q;
  logic [1:0]        state_d;
  logic [BYTE_W-1:0] byte_cnt_q;
  logic [BYTE_W-1:0] byte_cnt_d;
  logic [7:0]        crc_q;
  logic [7:0]        crc_d;
  logic              apply_q;
  logic              apply_d;
  logic              done_q;
  logic              done_d;
  logic              err_q;
  logic              err_d;

  logic ser_en;
  logic ser_ready;
  logic ser_last;
  logic data_acc;

  // Data bytes are only offered to the serializer until the full payload is in;
  // this also keeps an early CRC byte out of the data path.
  assign ser_en   = (state_q == LOAD) && (byte_cnt_q < NBYTES_C);
  assign data_acc = ser_ready && DIN_VALID;

  pal_cfg_serializer u_ser (
    .clk         (CLK),
    .srst        (RES),
    .en_i        (ser_en),
    .data_i      (DIN),
    .valid_i     (DIN_VALID),
    .ready_o     (ser_ready),
    .cfg_out_o   (CFG_OUT),
    .cfg_shift_o (CFG_SHIFT),
    .last_bit_o  (ser_last)
  );

  assign DIN_READY = ser_ready || (state_q == CHECK);
  assign BUSY      = (state_q != IDLE);
  assign CFG_APPLY = apply_q;
  assign DONE      = done_q;
  assign ERR       = err_q;

  // Load sequencing, CRC accumulation and the apply/error decision.
  always_comb begin
    state_d    = state_q;
    byte_cnt_d = byte_cnt_q;
    crc_d      = crc_q;
    apply_d    = 1'b0;
    done_d     = done_q;
    err_d      = err_q;
    case (state_q)
      IDLE: begin
        if (START) begin
          done_d     = 1'b0;
          err_d      = 1'b0;
          crc_d      = 8'h00;
          byte_cnt_d = '0;
          state_d    = LOAD;
        end
      end
      LOAD: begin
        if (data_acc) begin
          crc_d = crc8_byte(crc_q, DIN, CRC_POLY);
          if (byte_cnt_q != NBYTES_C) begin
            byte_cnt_d = byte_cnt_q + BYTE_W'(1);
          end
        end
        // Only the final byte's last bit can coincide with a full byte count.
        if ((byte_cnt_q == NBYTES_C) && ser_last) begin
          state_d = CHECK;
        end
      end
      CHECK: begin
        if (DIN_VALID) begin
          if (DIN == crc_q) begin
            state_d = APPLY;
          end else begin
            err_d   = 1'b1;
            state_d = IDLE;
          end
        end
      end
      APPLY: begin
        apply_d = 1'b1;
        done_d  = 1'b1;
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State, counters and status flags; reset aborts any load without applying.
  always_ff @(posedge CLK) begin
    if (RES) begin
      state_q    <= IDLE;
      byte_cnt_q <= '0;
      crc_q      <= 8'h00;
      apply_q    <= 1'b0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      byte_cnt_q <= byte_cnt_d;
      crc_q      <= crc_d;
      apply_q    <= apply_d;
      done_q     <= done_d;
      err_q      <= err_d;
    end
  end

endmodule

// File: tb/tb_pal_cfg_loader.sv
// Directed bench for pal_cfg_loader: all-zero load, bit order, CRC failure,
// backpressure, reset mid-load and START while busy / at the apply cycle.
`timescale 1ns/1ps
module tb_pal_cfg_loader;

  logic       CLK = 1'b0;
  logic       RES = 1'b1;
  logic       START = 1'b0;
  logic [7:0] DIN = 8'h00;
  logic       DIN_VALID = 1'b0;
  logic       DIN_READY;
  logic       CFG_OUT;
  logic       CFG_SHIFT;
  logic       CFG_APPLY;
  logic       BUSY;
  logic       DONE;
  logic       ERR;

  pal_cfg_loader dut (
    .CLK       (CLK),
    .RES       (RES),
    .START     (START),
    .DIN       (DIN),
    .DIN_VALID (DIN_VALID),
    .DIN_READY (DIN_READY),
    .CFG_OUT   (CFG_OUT),
    .CFG_SHIFT (CFG_SHIFT),
    .CFG_APPLY (CFG_APPLY),
    .BUSY      (BUSY),
    .DONE      (DONE),
    .ERR       (ERR)
  );

  always #5 CLK = ~CLK;

  int checks = 0;
  int failures = 0;
  int timeouts = 0;
  int cyc = 0;
  int first_acc = 0;
  int crc_acc = 0;

  logic [7:0] payload [48];

  logic bits_q[$];
  int   shift_cyc_q[$];
  int   apply_cnt = 0;
  int   last_apply_cyc = -1;

  always @(posedge CLK) cyc <= cyc + 1;

  // Capture every shifted bit and apply strobe.
  always @(negedge CLK) begin
    if (CFG_SHIFT === 1'b1) begin
      bits_q.push_back(CFG_OUT);
      shift_cyc_q.push_back(cyc);
    end
    if (CFG_APPLY === 1'b1) begin
      apply_cnt      <= apply_cnt + 1;
      last_apply_cyc <= cyc;
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] model_crc();
    logic [7:0] c;
    logic fb;
    c = 8'h00;
    for (int i = 0; i < 48; i++) begin
      for (int j = 7; j >= 0; j--) begin
        fb = c[7] ^ payload[i][j];
        c  = {c[6:0], 1'b0} ^ (fb ? 8'h07 : 8'h00);
      end
    end
    return c;
  endfunction

  task automatic send_byte(input logic [7:0] b, input int duty, input logic st, output int acc_cyc);
    bit ok = 1'b0;
    int w = 0;
    acc_cyc = -1;
    while (!ok && w < 400) begin
      @(negedge CLK);
      START     = st;
      DIN       = b;
      DIN_VALID = ($urandom_range(0, 99) < duty);
      if (DIN_VALID && DIN_READY) begin
        ok      = 1'b1;
        acc_cyc = cyc;
      end
      w++;
    end
    if (!ok) timeouts++;
  endtask

  task automatic run_load(input bit do_start, input int duty, input logic [7:0] crc_b,
                          input int start_at, input int abort_at);
    int a;
    if (do_start) begin
      @(negedge CLK);
      START = 1'b1;
      @(negedge CLK);
      START = 1'b0;
    end
    for (int i = 0; i < 48; i++) begin
      send_byte(payload[i], duty, (i == start_at), a);
      if (i == 0) first_acc = a;
      if (i == abort_at - 1) begin
        @(negedge CLK);
        DIN_VALID = 1'b0;
        START     = 1'b0;
        RES       = 1'b1;
        return;
      end
    end
    send_byte(crc_b, duty, 1'b0, a);
    crc_acc = a;
    @(negedge CLK);
    DIN_VALID = 1'b0;
    START     = 1'b0;
  endtask

  task automatic wait_idle();
    int w = 0;
    do begin
      @(negedge CLK);
      w++;
    end while (BUSY && w < 20);
    #1;
    chk("idle_reached", BUSY, 0);
  endtask

  task automatic check_stream(input int base, input string tag);
    int n;
    int mism;
    n = bits_q.size() - base;
    mism = 0;
    chk({tag, "_nbits"}, n, 384);
    for (int i = 0; i < 384 && (base + i) < bits_q.size(); i++) begin
      if (bits_q[base + i] !== payload[i / 8][7 - (i % 8)]) mism++;
    end
    chk({tag, "_bit_mismatches"}, mism, 0);
  endtask

  initial begin
    int b;
    int ac;
    logic [7:0] f8;

    // Reset, with START held high to show reset wins.
    RES   = 1'b1;
    START = 1'b1;
    repeat (3) @(negedge CLK);
    chk("reset_outputs", {25'b0, DIN_READY, CFG_OUT, CFG_SHIFT, CFG_APPLY, BUSY, DONE, ERR}, 0);
    START = 1'b0;
    RES   = 1'b0;
    @(negedge CLK);
    $display("step reset: outputs idle after reset");

    // All-zero load with zero gaps.
    for (int i = 0; i < 48; i++) payload[i] = 8'h00;
    b  = bits_q.size();
    ac = apply_cnt;
    run_load(1'b1, 100, 8'h00, -1, -1);
    wait_idle();
    check_stream(b, "zero");
    if (bits_q.size() >= b + 384) begin
      chk("zero_first_shift_lat", shift_cyc_q[b] - first_acc, 1);
      chk("zero_shift_span", shift_cyc_q[b + 383] - shift_cyc_q[b] + 1, 384);
      chk("zero_last_bit_lat", shift_cyc_q[b + 383] - first_acc, 384);
    end
    chk("zero_crc_accept_lat", crc_acc - first_acc, 385);
    chk("zero_apply_count", apply_cnt - ac, 1);
    chk("zero_apply_lat", last_apply_cyc - crc_acc, 2);
    chk("zero_done_err", {DONE, ERR}, 2'b10);
    $display("step zero: all-zero load done=%0b err=%0b", DONE, ERR);

    // Bit order: 0xA5 first.
    payload[0] = 8'hA5;
    b  = bits_q.size();
    ac = apply_cnt;
    run_load(1'b1, 100, model_crc(), -1, -1);
    wait_idle();
    f8 = 8'h00;
    if (bits_q.size() >= b + 8) begin
      for (int i = 0; i < 8; i++) f8 = {f8[6:0], bits_q[b + i]};
    end
    chk("a5_first_byte", f8, 8'hA5);
    check_stream(b, "a5");
    chk("a5_apply_count", apply_cnt - ac, 1);
    chk("a5_done_err", {DONE, ERR}, 2'b10);
    $display("step a5: first byte bits 0x%02h", f8);

    // CRC failure.
    payload[0] = 8'h00;
    ac = apply_cnt;
    run_load(1'b1, 100, 8'h01, -1, -1);
    wait_idle();
    repeat (3) @(negedge CLK);
    #1;
    chk("crcfail_apply_count", apply_cnt - ac, 0);
    chk("crcfail_done_err", {DONE, ERR}, 2'b01);
    chk("crcfail_ready_idle", DIN_READY, 0);
    $display("step crcfail: done=%0b err=%0b", DONE, ERR);

    // Backpressure with random data.
    for (int i = 0; i < 48; i++) payload[i] = 8'($urandom);
    b  = bits_q.size();
    ac = apply_cnt;
    run_load(1'b1, 30, model_crc(), -1, -1);
    wait_idle();
    check_stream(b, "bp");
    chk("bp_apply_count", apply_cnt - ac, 1);
    chk("bp_done_err", {DONE, ERR}, 2'b10);
    $display("step backpressure: %0d bits captured", bits_q.size() - b);

    // Reset after 10 bytes.
    for (int i = 0; i < 48; i++) payload[i] = 8'($urandom);
    ac = apply_cnt;
    run_load(1'b1, 100, model_crc(), -1, 10);
    @(negedge CLK);
    #1;
    chk("abort_outputs", {25'b0, DIN_READY, CFG_OUT, CFG_SHIFT, CFG_APPLY, BUSY, DONE, ERR}, 0);
    RES = 1'b0;
    repeat (5) @(negedge CLK);
    #1;
    chk("abort_no_apply", apply_cnt - ac, 0);
    chk("abort_idle", BUSY, 0);
    b  = bits_q.size();
    ac = apply_cnt;
    run_load(1'b1, 100, model_crc(), -1, -1);
    wait_idle();
    check_stream(b, "reload");
    chk("reload_apply_count", apply_cnt - ac, 1);
    chk("reload_done_err", {DONE, ERR}, 2'b10);
    $display("step abort: reload done=%0b", DONE);

    // START at byte 5 is ignored; START in the apply cycle begins a new load.
    for (int i = 0; i < 48; i++) payload[i] = 8'($urandom);
    b  = bits_q.size();
    ac = apply_cnt;
    run_load(1'b1, 100, model_crc(), 5, -1);
    wait_idle();
    check_stream(b, "busystart");
    chk("busystart_apply_count", apply_cnt - ac, 1);
    chk("busystart_apply_now", CFG_APPLY, 1);
    START = 1'b1;
    @(negedge CLK);
    START = 1'b0;
    chk("restart_busy", BUSY, 1);
    chk("restart_done_cleared", DONE, 0);
    for (int i = 0; i < 48; i++) payload[i] = 8'h00;
    b  = bits_q.size();
    ac = apply_cnt;
    run_load(1'b0, 100, 8'h00, -1, -1);
    wait_idle();
    check_stream(b, "restart");
    chk("restart_apply_count", apply_cnt - ac, 1);
    chk("restart_done_err", {DONE, ERR}, 2'b10);
    $display("step restart: second load done=%0b", DONE);

    chk("handshake_timeouts", timeouts, 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
